// File: rtl/block_ram_multi_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : block_ram_multi_word_loader
// Brief    : Packs a valid/ready word stream into consecutive multi-word RAM
//            rows via one-hot per-word write enables.
// Revision : 1.0
// ============================================================================
module block_ram_multi_word_loader #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 64,
    parameter  int NUM_WORDS  = 9*32,
    parameter  int NUM_ROWS   = 64,
    localparam int AW         = (DEPTH > 1)     ? $clog2(DEPTH)     : 1,
    localparam int WW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int RW         = (NUM_ROWS > 1)  ? $clog2(NUM_ROWS)  : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [AW-1:0]         ram_addr,
    output logic [NUM_WORDS-1:0]  ram_wr_en,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [NUM_WORDS-1:0] WORD0_EN = NUM_WORDS'(1);

    state_t                  state_q;
    logic [AW-1:0]           addr_q;
    logic [WW-1:0]           word_cnt_q;
    logic [RW-1:0]           row_cnt_q;
    logic                    in_ready_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [AW-1:0]           ram_addr_q;
    logic [NUM_WORDS-1:0]    wr_en_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    w_beat;
    logic                    w_last_word;
    logic                    w_last_row;
    logic [WW-1:0]           word_cnt_d;
    logic [RW-1:0]           row_cnt_d;
    logic [AW-1:0]           addr_d;

    always_comb begin
        w_beat      = (state_q == S_LOAD) && in_ready_q && in_valid;
        w_last_word = (word_cnt_q == WW'(NUM_WORDS - 1));
        w_last_row  = (row_cnt_q  == RW'(NUM_ROWS - 1));
        word_cnt_d  = word_cnt_q + WW'(1);
        row_cnt_d   = row_cnt_q;
        addr_d      = addr_q;
        // Row boundary: restart word index and advance the row address modulo DEPTH.
        if (w_last_word) begin
            word_cnt_d = '0;
            row_cnt_d  = row_cnt_q + RW'(1);
            addr_d     = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            wr_data_q  <= '0;
            ram_addr_q <= '0;
            wr_en_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_en_q <= '0;
                    done_q  <= 1'b0;
                    if (start) begin
                        addr_q     <= base_addr;
                        word_cnt_q <= '0;
                        row_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        wr_data_q  <= in_data;
                        ram_addr_q <= addr_q;
                        wr_en_q    <= WORD0_EN << word_cnt_q;
                        word_cnt_q <= word_cnt_d;
                        row_cnt_q  <= row_cnt_d;
                        addr_q     <= addr_d;
                        if (w_last_word && w_last_row) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_FLUSH;
                        end
                    end else begin
                        wr_en_q <= '0;
                    end
                end
                S_FLUSH: begin
                    wr_en_q <= '0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign ram_wr_data = wr_data_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_en   = wr_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_block_ram_multi_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_ram_multi_word_loader
// Brief    : Scoreboard bench for the multi-word RAM loader with a small RAM model.
// Revision : 1.0
// ============================================================================
module tb_block_ram_multi_word_loader;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NW    = 3;
    localparam int NR    = 2;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_addr;
    logic [NW-1:0] ram_wr_en;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    block_ram_multi_word_loader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_WORDS  (NW),
        .NUM_ROWS   (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ram_wr_data (ram_wr_data),
        .ram_addr    (ram_addr),
        .ram_wr_en   (ram_wr_en),
        .busy        (busy),
        .done        (done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [NW-1:0] en;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            n_cmp    = 0;
    int            n_err    = 0;
    int            done_cnt = 0;
    logic [DW-1:0] mem [0:DEPTH-1][0:NW-1];

    // Attached RAM: per-word write enables on port A.
    always @(posedge clk) begin
        for (int i = 0; i < NW; i++)
            if (ram_wr_en[i] === 1'b1) mem[ram_addr][i] <= ram_wr_data;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (ram_wr_en !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d en=%b data=0x%0h, required no write",
                         ram_addr, ram_wr_en, ram_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ram_addr, ram_wr_en, ram_wr_data} !== mon_e) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d en=%b data=0x%0h, required addr=%0d en=%b data=0x%0h",
                             ram_addr, ram_wr_en, ram_wr_data, mon_e.addr, mon_e.en, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] row(input int a);
        return {8'h00, mem[a][2], mem[a][1], mem[a][0]};
    endfunction

    task automatic push(input logic [AW-1:0] a, input logic [NW-1:0] e, input logic [DW-1:0] d);
        exp_q.push_back('{addr: a, en: e, data: d});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick(1);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_in_load", in_ready, 1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            tick(1);
            t++;
        end
        if (t == 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_timeout: got in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
        tick(1);
    endtask

    // Called right after the final beat is accepted: FLUSH, DONE, back to IDLE.
    task automatic finish_check(input int exp_done);
        check("in_ready_flush", in_ready, 0);
        check("busy_flush", busy, 1);
        tick(1);
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("wr_en_done", ram_wr_en, 0);
        check("in_ready_done", in_ready, 0);
        tick(1);
        check("done_single", done, 0);
        check("done_count", done_cnt, exp_done);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required $finish before time limit");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        tick(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_wr_data", ram_wr_data, 0);
        check("rst_addr", ram_addr, 0);
        rst = 1'b0;

        // Valid in IDLE is ignored.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick(3);
        check("idle_in_ready", in_ready, 0);
        check("idle_wr_en", ram_wr_en, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Full load from row 0, no stalls; valid stays high through FLUSH.
        push(2'd0, 3'b001, 8'h10); push(2'd0, 3'b010, 8'h11); push(2'd0, 3'b100, 8'h12);
        push(2'd1, 3'b001, 8'h13); push(2'd1, 3'b010, 8'h14); push(2'd1, 3'b100, 8'h15);
        do_start(2'd0);
        for (int i = 0; i < 6; i++) send_beat(8'(8'h10 + i));
        in_data = 8'hEE;
        finish_check(1);
        in_valid = 1'b0;
        check("row0_s1", row(0), 32'h121110);
        check("row1_s1", row(1), 32'h151413);

        // Address wrap from the last row.
        push(2'd3, 3'b001, 8'h30); push(2'd3, 3'b010, 8'h31); push(2'd3, 3'b100, 8'h32);
        push(2'd0, 3'b001, 8'h33); push(2'd0, 3'b010, 8'h34); push(2'd0, 3'b100, 8'h35);
        do_start(2'd3);
        for (int i = 0; i < 6; i++) send_beat(8'(8'h30 + i));
        in_valid = 1'b0;
        finish_check(2);
        check("row3_s2", row(3), 32'h323130);
        check("row0_s2", row(0), 32'h353433);

        // Valid gaps 1,0,0 with a stray start during LOAD.
        push(2'd0, 3'b001, 8'h10); push(2'd0, 3'b010, 8'h11); push(2'd0, 3'b100, 8'h12);
        push(2'd1, 3'b001, 8'h13); push(2'd1, 3'b010, 8'h14); push(2'd1, 3'b100, 8'h15);
        do_start(2'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("no_early_done", done_cnt, 2);
            send_beat(8'(8'h10 + i));
            if (i < 5) begin
                in_valid = 1'b0;
                if (i == 1) begin
                    start     = 1'b1;
                    base_addr = 2'd2;
                end
                tick(1);
                start = 1'b0;
                check("gap_wr_en", ram_wr_en, 0);
                tick(1);
            end
        end
        in_valid = 1'b0;
        finish_check(3);
        check("row0_s3", row(0), 32'h121110);
        check("row1_s3", row(1), 32'h151413);

        // Reset after four beats, then a clean reload.
        push(2'd1, 3'b001, 8'h40); push(2'd1, 3'b010, 8'h41); push(2'd1, 3'b100, 8'h42);
        push(2'd2, 3'b001, 8'h43);
        do_start(2'd1);
        for (int i = 0; i < 4; i++) send_beat(8'(8'h40 + i));
        rst     = 1'b1;
        in_data = 8'h44;
        tick(1);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", ram_wr_en, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        tick(3);
        check("midrst_no_done", done_cnt, 3);
        check("midrst_queue", exp_q.size(), 0);
        in_valid = 1'b0;

        push(2'd1, 3'b001, 8'h50); push(2'd1, 3'b010, 8'h51); push(2'd1, 3'b100, 8'h52);
        push(2'd2, 3'b001, 8'h53); push(2'd2, 3'b010, 8'h54); push(2'd2, 3'b100, 8'h55);
        do_start(2'd1);
        for (int i = 0; i < 6; i++) send_beat(8'(8'h50 + i));
        in_valid = 1'b0;
        finish_check(4);
        check("row1_s5", row(1), 32'h525150);
        check("row2_s5", row(2), 32'h555453);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
